// File: rtl/stavka_a.sv
// -----------------------------------------------------------------------------
// stavka_a_core
//
// Two-operand mini floating-point arithmetic unit. Each operand is a 3-bit
// unsigned mantissa and a 3-bit unsigned exponent, value m * 2^e.
//   control = 1 : multiply      -> m_out = m1*m2,   e_out = e1+e2
//   control = 0 : aligned add   -> the smaller-exponent mantissa is shifted
//                                  right by |e1-e2| (truncating),
//                                  m_out = m1' + m2', e_out = max(e1,e2)
// The result is not normalised, rounded or saturated. The widths always hold
// the exact result.
//
// Optional build macro:
//   STAVKA_A_IN_REG_EN - adds a reset-to-zero input register stage on
//                        control/m1/e1/m2/e2/in_valid. Latency becomes 2
//                        cycles instead of 1. Throughput is unchanged.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   in_valid  in   1  operands valid this cycle
//   control   in   1  1 = multiply, 0 = add
//   m1, e1    in   3  operand 1 mantissa / exponent
//   m2, e2    in   3  operand 2 mantissa / exponent
//   m_out     out  6  result mantissa (registered, holds when idle)
//   e_out     out  4  result exponent (registered, holds when idle)
//   out_valid out  1  result valid (registered)
// -----------------------------------------------------------------------------
module stavka_a_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       control,
    input  logic [2:0] m1,
    input  logic [2:0] e1,
    input  logic [2:0] m2,
    input  logic [2:0] e2,
    output logic [5:0] m_out,
    output logic [3:0] e_out,
    output logic       out_valid
);

    localparam int unsigned MW  = 3;
    localparam int unsigned EW  = 3;
    localparam int unsigned RMW = 6;
    localparam int unsigned REW = 4;

    // Operands as seen by the datapath
    logic          s_valid;
    logic          s_control;
    logic [MW-1:0] s_m1;
    logic [EW-1:0] s_e1;
    logic [MW-1:0] s_m2;
    logic [EW-1:0] s_e2;

`ifdef STAVKA_A_IN_REG_EN
    // Input register stage: isolates the port timing from the datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid   <= 1'b0;
            s_control <= 1'b0;
            s_m1      <= '0;
            s_e1      <= '0;
            s_m2      <= '0;
            s_e2      <= '0;
        end else begin
            s_valid   <= in_valid;
            s_control <= control;
            s_m1      <= m1;
            s_e1      <= e1;
            s_m2      <= m2;
            s_e2      <= e2;
        end
    end
`else
    // Datapath fed straight from the ports
    assign s_valid   = in_valid;
    assign s_control = control;
    assign s_m1      = m1;
    assign s_e1      = e1;
    assign s_m2      = m2;
    assign s_e2      = e2;
`endif

    // Combinational datapath
    logic [EW-1:0]  emax_c;
    logic [EW-1:0]  diff_c;
    logic [MW-1:0]  m1_al_c;
    logic [MW-1:0]  m2_al_c;
    logic [RMW-1:0] sum_c;
    logic [RMW-1:0] prod_c;
    logic [REW-1:0] esum_c;
    logic [RMW-1:0] res_m_c;
    logic [REW-1:0] res_e_c;

    always_comb begin
        emax_c  = '0;
        diff_c  = '0;
        m1_al_c = s_m1;
        m2_al_c = s_m2;
        sum_c   = '0;
        prod_c  = '0;
        esum_c  = '0;
        res_m_c = '0;
        res_e_c = '0;

        // Align: shift the smaller-exponent mantissa; a shift >= 3 yields 0.
        // Equal exponents take the first branch with diff 0, i.e. no shift.
        if (s_e1 >= s_e2) begin
            emax_c  = s_e1;
            diff_c  = s_e1 - s_e2;
            m2_al_c = s_m2 >> diff_c;
        end else begin
            emax_c  = s_e2;
            diff_c  = s_e2 - s_e1;
            m1_al_c = s_m1 >> diff_c;
        end

        sum_c  = RMW'(m1_al_c) + RMW'(m2_al_c);
        prod_c = RMW'(s_m1) * RMW'(s_m2);
        esum_c = REW'(s_e1) + REW'(s_e2);

        if (s_control) begin
            res_m_c = prod_c;
            res_e_c = esum_c;
        end else begin
            res_m_c = sum_c;
            res_e_c = {1'b0, emax_c};
        end
    end

    // Output register: result held while idle, valid follows the sampled valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out     <= '0;
            e_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s_valid;
            if (s_valid) begin
                m_out <= res_m_c;
                e_out <= res_e_c;
            end
        end
    end

endmodule

// File: tb/tb_stavka_a_core.sv
// -----------------------------------------------------------------------------
// Self-checking bench for stavka_a_core. A value-level reference model
// (integer multiply / divide-by-power-of-two alignment) feeds a latency queue
// that mirrors the configured pipeline depth.
// -----------------------------------------------------------------------------
module tb_stavka_a_core;

`ifdef STAVKA_A_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       control;
    logic [2:0] m1, e1, m2, e2;
    logic [5:0] m_out;
    logic [3:0] e_out;
    logic       out_valid;

    always #5 clk = ~clk;

    stavka_a_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .control  (control),
        .m1       (m1),
        .e1       (e1),
        .m2       (m2),
        .e2       (e2),
        .m_out    (m_out),
        .e_out    (e_out),
        .out_valid(out_valid)
    );

    typedef struct {
        bit v;
        int m;
        int e;
    } item_t;

    item_t pipe[$];
    int    mod_m;
    int    mod_e;
    bit    mod_v;
    int    errors;
    int    checks;

    // Value-level reference: aligned add divides the smaller-exponent
    // mantissa by 2^d (integer truncation), multiply is plain arithmetic.
    function automatic void ref_calc(input int c, input int a1, input int x1,
                                     input int a2, input int x2,
                                     output int rm, output int re);
        if (c != 0) begin
            rm = a1 * a2;
            re = x1 + x2;
        end else if (x1 >= x2) begin
            rm = a1 + a2 / (2 ** (x1 - x2));
            re = x1;
        end else begin
            rm = a1 / (2 ** (x2 - x1)) + a2;
            re = x2;
        end
    endfunction

    task automatic check_out(input string tag);
        checks++;
        assert (m_out === 6'(mod_m)) else begin
            errors++;
            $error("FAIL %s m_out got %0d want %0d", tag, m_out, mod_m);
        end
        checks++;
        assert (e_out === 4'(mod_e)) else begin
            errors++;
            $error("FAIL %s e_out got %0d want %0d", tag, e_out, mod_e);
        end
        checks++;
        assert (out_valid === mod_v) else begin
            errors++;
            $error("FAIL %s out_valid got %0b want %0b", tag, out_valid, mod_v);
        end
    endtask

    // Drive one cycle of inputs at negedge, advance the model at the
    // posedge, then check the outputs just after the edge.
    task automatic cycle(input bit v, input bit c, input int a1, input int x1,
                         input int a2, input int x2, input string tag);
        item_t it;
        @(negedge clk);
        in_valid = v;
        control  = c;
        m1 = 3'(a1);
        e1 = 3'(x1);
        m2 = 3'(a2);
        e2 = 3'(x2);
        @(posedge clk);
        it.v = v;
        ref_calc(int'(c), a1, x1, a2, x2, it.m, it.e);
        pipe.push_back(it);
        if (pipe.size() >= LAT) begin
            it = pipe.pop_front();
            mod_v = it.v;
            if (it.v) begin
                mod_m = it.m;
                mod_e = it.e;
            end
        end
        #1;
        check_out(tag);
    endtask

    task automatic model_reset();
        pipe.delete();
        mod_m = 0;
        mod_e = 0;
        mod_v = 1'b0;
    endtask

    initial begin
        bit [12:0] w;
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        control  = 1'b0;
        m1 = '0; e1 = '0; m2 = '0; e2 = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_out("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the test plan
        cycle(1, 1, 7, 7, 7, 7, "mul_extreme");
        cycle(1, 0, 5, 2, 3, 2, "add_equal_exp");
        cycle(1, 0, 6, 4, 5, 3, "add_align");
        cycle(1, 0, 5, 3, 6, 4, "add_align_mirror");
        cycle(1, 0, 7, 0, 1, 3, "add_trunc");
        cycle(1, 1, 0, 5, 6, 2, "mul_zero");
        for (int i = 0; i < LAT + 1; i++)
            cycle(0, 0, 0, 0, 0, 0, "drain_directed");

        // Absolute expectations for the directed extreme cases
        cycle(1, 1, 7, 7, 7, 7, "mul_extreme_abs");
        for (int i = 0; i < LAT - 1; i++)
            cycle(0, 0, 1, 1, 1, 1, "wait_abs");
        checks++;
        assert (m_out === 6'd49 && e_out === 4'd14 && out_valid === 1'b1) else begin
            errors++;
            $error("FAIL mul_extreme_const got m=%0d e=%0d v=%0b want m=49 e=14 v=1",
                   m_out, e_out, out_valid);
        end
        cycle(0, 0, 2, 2, 2, 2, "drain_abs");

        // Exhaustive back-to-back sweep; out_valid is checked every cycle
        for (int i = 0; i < 8192; i++) begin
            w = 13'(i);
            cycle(1, w[12], int'(w[11:9]), int'(w[8:6]), int'(w[5:3]),
                  int'(w[2:0]), "sweep");
        end
        for (int i = 0; i < LAT + 1; i++)
            cycle(0, 0, 0, 0, 0, 0, "drain_sweep");

        // Random stream, then reset asserted mid-stream
        for (int i = 0; i < 20; i++)
            cycle(1, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), "rand_pre_reset");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_out("reset_mid_async");
        @(posedge clk);
        #1;
        check_out("reset_mid_held");
        @(negedge clk);
        rst_n = 1'b1;

        // First valids after release behave as from idle
        for (int i = 0; i < 12; i++)
            cycle(1, 1'($urandom_range(0, 1)), $urandom_range(1, 7),
                  $urandom_range(0, 7), $urandom_range(1, 7),
                  $urandom_range(0, 7), "rand_post_reset");

        // Idle with wiggling operands: result holds, out_valid drops
        for (int i = 0; i < 8; i++)
            cycle(0, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), "hold_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout sim time exceeded got running want finished");
        $fatal(1, "timeout");
    end

endmodule
